// File: rtl/encoder_pkg.sv
// Shared definitions for the key front-end and the 4-input encoder it feeds.
// Channel FSM state encoding and the default debounce length.
package encoder_pkg;

  typedef enum logic [1:0] {
    S_LO   = 2'd0,
    S_RISE = 2'd1,
    S_HI   = 2'd2,
    S_FALL = 2'd3
  } state_t;

  localparam int DB_CYCLES_DEF = 16;

endpackage

// File: rtl/debounce_ch.sv
// One key channel: 2-flop synchroniser, qualification FSM and run-length counter.
// level/press/rel are registered; accept is the next-cycle press|rel, used for the shared strobe.
module debounce_ch
  import encoder_pkg::*;
#(
  parameter  int DB_CYCLES = DB_CYCLES_DEF,
  localparam int CNT_W     = $clog2(DB_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel,
  output logic accept
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic             s1;
  logic             s2;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             at_max;

  assign at_max = (cnt == CNT_MAX);
  assign accept = at_max && (((state == S_RISE) && s2) || ((state == S_FALL) && !s2));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      state <= S_LO;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      press <= 1'b0;
      rel   <= 1'b0;
      case (state)
        S_LO: begin
          if (s2) begin
            state <= S_RISE;
            cnt   <= CNT_W'(1);
          end
        end
        S_RISE: begin
          // Any opposite sample throws the run away; qualification restarts from zero.
          if (!s2) begin
            state <= S_LO;
            cnt   <= '0;
          end else if (at_max) begin
            state <= S_HI;
            level <= 1'b1;
            press <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_HI: begin
          if (!s2) begin
            state <= S_FALL;
            cnt   <= CNT_W'(1);
          end
        end
        S_FALL: begin
          if (s2) begin
            state <= S_HI;
            cnt   <= '0;
          end else if (at_max) begin
            state <= S_LO;
            level <= 1'b0;
            rel   <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= S_LO;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_debounce_4ch.sv
// N-channel key debouncer driving the encoder's x input, with press/release pulses
// and a registered any-change strobe aligned with those pulses.
module key_debounce_4ch
  import encoder_pkg::*;
#(
  parameter int N         = 4,
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] raw_in,
  output logic [N-1:0] x,
  output logic [N-1:0] press,
  output logic [N-1:0] rel,
  output logic         changed
);

  if (DB_CYCLES < 2) begin : g_bad_db
    $error("DB_CYCLES must be at least 2");
  end

  logic [N-1:0] accept;

  for (genvar i = 0; i < N; i++) begin : g_ch
    debounce_ch #(
      .DB_CYCLES(DB_CYCLES)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .raw   (raw_in[i]),
      .level (x[i]),
      .press (press[i]),
      .rel   (rel[i]),
      .accept(accept[i])
    );
  end

  // Built from each channel's accept so the strobe lands in the same cycle as press/rel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      changed <= 1'b0;
    end else begin
      changed <= |accept;
    end
  end

endmodule

// File: tb/tb_key_debounce_4ch.sv
// Bench for key_debounce_4ch at DB_CYCLES=4: vector table, hand-written corner cases,
// and random key activity compared against a sliding-window reference model.
module tb_key_debounce_4ch;

  localparam int N  = 4;
  localparam int DB = 4;
  localparam int HL = DB + 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] raw_in = 4'hF;
  logic [N-1:0] x;
  logic [N-1:0] press;
  logic [N-1:0] rel;
  logic         changed;

  always #5 clk = ~clk;

  key_debounce_4ch #(.N(N), .DB_CYCLES(DB)) dut (
    .clk    (clk),
    .rst    (rst),
    .raw_in (raw_in),
    .x      (x),
    .press  (press),
    .rel    (rel),
    .changed(changed)
  );

  int errors = 0;
  int checks = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference: the accepted level flips when the last DB synchronised samples all
  // disagree with it; samples reach the decision two edges after raw_in is taken.
  logic [N-1:0] hist [HL];
  logic [N-1:0] mx, mpress, mrel;
  logic         mchg;

  function automatic void model_reset();
    for (int i = 0; i < HL; i++) hist[i] = '0;
    mx = '0; mpress = '0; mrel = '0; mchg = 1'b0;
  endfunction

  function automatic void model_edge(input logic [N-1:0] r);
    for (int i = HL - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = r;
    mpress = '0;
    mrel   = '0;
    for (int c = 0; c < N; c++) begin
      bit all_diff = 1'b1;
      for (int j = 2; j < HL; j++) if (hist[j][c] == mx[c]) all_diff = 1'b0;
      if (all_diff) begin
        if (mx[c]) mrel[c] = 1'b1; else mpress[c] = 1'b1;
        mx[c] = ~mx[c];
      end
    end
    mchg = |(mpress | mrel);
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst) model_reset(); else model_edge(raw_in);
    #1;
    chk("model", {x, press, rel, changed}, {mx, mpress, mrel, mchg});
  endtask

  function automatic logic [2:0] enc(input logic [N-1:0] v);
    return {|v, v[2] | v[3], v[1] | v[3]};
  endfunction

  typedef struct {
    logic [N-1:0] raw;
    logic [N-1:0] x;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic         changed;
  } vec_t;

  vec_t tbl [14];

  initial begin
    logic [N-1:0] acc_p, acc_r, prev, pat;
    int           n_seen, idx, hold [N];

    tbl = '{
      '{4'h1, 4'h0, 4'h0, 4'h0, 1'b0}, '{4'h1, 4'h0, 4'h0, 4'h0, 1'b0},
      '{4'h1, 4'h0, 4'h0, 4'h0, 1'b0}, '{4'h1, 4'h0, 4'h0, 4'h0, 1'b0},
      '{4'h1, 4'h0, 4'h0, 4'h0, 1'b0}, '{4'h1, 4'h1, 4'h1, 4'h0, 1'b1},
      '{4'h1, 4'h1, 4'h0, 4'h0, 1'b0}, '{4'h0, 4'h1, 4'h0, 4'h0, 1'b0},
      '{4'h0, 4'h1, 4'h0, 4'h0, 1'b0}, '{4'h0, 4'h1, 4'h0, 4'h0, 1'b0},
      '{4'h0, 4'h1, 4'h0, 4'h0, 1'b0}, '{4'h0, 4'h1, 4'h0, 4'h0, 1'b0},
      '{4'h0, 4'h0, 4'h0, 4'h1, 1'b1}, '{4'h0, 4'h0, 4'h0, 4'h0, 1'b0}
    };
    model_reset();

    // Reset held with all keys down: everything stays zero.
    repeat (3) begin
      step();
      chk("reset_hold", {x, press, rel, changed}, '0);
    end
    rst = 1'b0;
    repeat (3) step();
    #2 rst = 1'b1; model_reset();
    #1 chk("reset_mid_rise", {x, press, rel, changed}, '0);
    step();
    rst = 1'b0;
    repeat (7) step();
    chk("x_all_high", x, 4'hF);
    #2 rst = 1'b1; model_reset();
    #1 chk("reset_async_x", {x, press, rel, changed}, '0);
    step();
    // Keys still held as reset drops: channels must qualify and press.
    rst = 1'b0;
    acc_p = '0;
    repeat (8) begin step(); acc_p |= press; end
    chk("press_after_reset", acc_p, 4'hF);
    raw_in = '0;
    repeat (8) step();

    for (int e = 0; e < 14; e++) begin
      raw_in = tbl[e].raw;
      step();
      chk("tbl", {x, press, rel, changed},
          {tbl[e].x, tbl[e].press, tbl[e].rel, tbl[e].changed});
    end
    repeat (4) step();

    // Glitch: three high samples never qualify.
    acc_p = '0; acc_r = '0;
    raw_in = 4'b0100;
    repeat (3) begin step(); acc_p |= press; acc_r |= rel; end
    raw_in = '0;
    repeat (10) begin step(); acc_p |= press; acc_r |= rel; end
    chk("glitch_pulses", {acc_p, acc_r}, '0);
    chk("glitch_x", x, '0);

    // Bounce: qualification restarts at the third sample.
    n_seen = 0; idx = -1;
    for (int i = 0; i < 14; i++) begin
      raw_in = (i == 1) ? 4'b0000 : 4'b0010;
      step();
      if (press[1]) begin n_seen++; idx = i; end
    end
    chk("bounce_press_count", n_seen, 1);
    chk("bounce_press_edge", idx, 7);
    raw_in = '0;
    repeat (8) step();

    // Two channels accepted in the same cycle, both directions.
    n_seen = 0;
    raw_in = 4'b1010;
    repeat (8) begin
      step();
      if (press != '0) begin n_seen++; chk("sim_press", press, 4'b1010); end
    end
    chk("sim_press_count", n_seen, 1);
    chk("sim_x", x, 4'b1010);
    n_seen = 0;
    raw_in = '0;
    repeat (8) begin
      step();
      if (rel != '0) begin n_seen++; chk("sim_rel", rel, 4'b1010); end
    end
    chk("sim_rel_count", n_seen, 1);

    // One-hot sweep into the encoder.
    prev = '0;
    for (int k = 0; k < N; k++) begin
      pat = '0;
      pat[k] = 1'b1;
      raw_in = pat;
      for (int i = 0; i < 8; i++) begin
        step();
        if (i == 4) chk("sweep_before", x, prev);
        if (i == 5) chk("sweep_after", x, pat);
      end
      chk("sweep_enc", enc(x), {1'b1, 2'(k)});
      prev = pat;
    end
    raw_in = '0;
    repeat (8) step();

    // Random key activity with per-channel hold lengths around the debounce window.
    for (int c = 0; c < N; c++) hold[c] = 0;
    acc_p = '0;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < N; c++) begin
        if (hold[c] == 0) begin
          raw_in[c] = 1'($urandom_range(0, 1));
          hold[c]   = $urandom_range(1, 8);
        end
        hold[c]--;
      end
      step();
      acc_p |= press & rel;
    end
    chk("press_rel_overlap", acc_p, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
